// File: rtl/snoop_initiator_pkg.sv
`default_nettype none
// ============================================================================
// snoop_initiator_pkg : ACE snoop channel (AC/CR/CD) types and helpers
// Revision: 1.0
// ============================================================================
package snoop_initiator_pkg;

  localparam int unsigned ACE_ADDR_WIDTH    = 64;
  localparam int unsigned ACE_DATA_WIDTH    = 64;
  localparam int unsigned DCACHE_LINE_WIDTH = 128;

  typedef enum logic [3:0] {
    READ_ONCE             = 4'b0000,
    READ_SHARED           = 4'b0001,
    READ_CLEAN            = 4'b0010,
    READ_NOT_SHARED_DIRTY = 4'b0011,
    READ_UNIQUE           = 4'b0111,
    CLEAN_SHARED          = 4'b1000,
    CLEAN_INVALID         = 4'b1001,
    MAKE_INVALID          = 4'b1101
  } acsnoop_t;

  typedef struct packed {
    logic isShared;
    logic passDirty;
    logic error;
    logic dataTransfer;
  } crresp_t;

  typedef struct packed {
    logic [ACE_ADDR_WIDTH-1:0] addr;
    acsnoop_t                  snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [ACE_DATA_WIDTH-1:0] data;
    logic                      last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef struct packed {
    logic                         dataTransfer;
    logic                         passDirty;
    logic                         isShared;
    logic                         error;
    logic [DCACHE_LINE_WIDTH-1:0] line;
  } snoop_init_resp_t;

  // Only these snoop types are ever issued toward the data cache.
  function automatic logic is_legal_snoop(acsnoop_t snoop);
    case (snoop)
      CLEAN_INVALID, READ_SHARED, READ_ONCE, READ_UNIQUE: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_initiator.sv
`default_nettype none
// ============================================================================
// snoop_initiator : issues one ACE snoop at a time and assembles the CD line
// Revision: 1.0
// ============================================================================
module snoop_initiator
  import snoop_initiator_pkg::*;
#(
  parameter int unsigned AddrWidth = ACE_ADDR_WIDTH,
  parameter int unsigned DataWidth = ACE_DATA_WIDTH,
  parameter int unsigned LineWidth = DCACHE_LINE_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [3:0]           req_snoop_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output snoop_init_resp_t     resp_o,
  output snoop_req_t           snoop_port_o,
  input  snoop_resp_t          snoop_port_i,
  output logic                 busy_o
);

  localparam int unsigned ByteOffset = $clog2(LineWidth / 8);
  localparam logic [AddrWidth-1:0] LineMask =
    {{(AddrWidth - ByteOffset){1'b1}}, {ByteOffset{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_AC = 3'd1,
    WAIT_CR = 3'd2,
    WAIT_CD = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  acsnoop_t             snoop_q, snoop_d;
  logic                 beat_q, beat_d;
  snoop_init_resp_t     resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    beat_d  = beat_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i & LineMask;
          snoop_d = acsnoop_t'(req_snoop_i);
          beat_d  = 1'b0;
          resp_d  = '0;
          if (is_legal_snoop(acsnoop_t'(req_snoop_i))) begin
            state_d = SEND_AC;
          end else begin
            resp_d.error = 1'b1;
            state_d      = RESP;
          end
        end
      end
      SEND_AC: begin
        if (snoop_port_i.ac_ready) state_d = WAIT_CR;
      end
      WAIT_CR: begin
        if (snoop_port_i.cr_valid) begin
          resp_d.dataTransfer = snoop_port_i.cr_resp.dataTransfer;
          resp_d.passDirty    = snoop_port_i.cr_resp.passDirty;
          resp_d.isShared     = snoop_port_i.cr_resp.isShared;
          resp_d.error        = snoop_port_i.cr_resp.error;
          // An errored CR that announces data still owes us both beats.
          state_d = snoop_port_i.cr_resp.dataTransfer ? WAIT_CD : RESP;
        end
      end
      WAIT_CD: begin
        if (snoop_port_i.cd_valid) begin
          beat_d = ~beat_q;
          if (!beat_q) begin
            resp_d.line[DataWidth-1:0] = snoop_port_i.cd.data;
            if (snoop_port_i.cd.last) resp_d.error = 1'b1;
          end else begin
            resp_d.line[LineWidth-1:DataWidth] = snoop_port_i.cd.data;
            if (!snoop_port_i.cd.last) resp_d.error = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      snoop_q <= READ_ONCE;
      beat_q  <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
    end
  end

  // All handshake outputs decode straight from state_q.
  always_comb begin
    snoop_port_o          = '0;
    snoop_port_o.ac_valid = (state_q == SEND_AC);
    snoop_port_o.ac.addr  = addr_q;
    snoop_port_o.ac.snoop = snoop_q;
    snoop_port_o.cr_ready = (state_q == WAIT_CR);
    snoop_port_o.cd_ready = (state_q == WAIT_CD);
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign resp_o       = resp_q;

  cd_valid_in_idle: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q == IDLE) |-> !snoop_port_i.cd_valid
  );

endmodule
`default_nettype wire

// File: tb/tb_snoop_initiator.sv
`default_nettype none
// ============================================================================
// tb_snoop_initiator : directed self-checking bench for snoop_initiator
// Revision: 1.0
// ============================================================================
module tb_snoop_initiator;
  import snoop_initiator_pkg::*;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [63:0]      req_addr_i;
  logic [3:0]       req_snoop_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  snoop_init_resp_t resp_o;
  snoop_req_t       snoop_port_o;
  snoop_resp_t      snoop_port_i;
  logic             busy_o;

  int checks = 0;
  int errors = 0;
  int ac_cnt = 0;
  int cd_rdy_cnt = 0;

  always #5 clk = ~clk;

  snoop_initiator dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_snoop_i  (req_snoop_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_o       (resp_o),
    .snoop_port_o (snoop_port_o),
    .snoop_port_i (snoop_port_i),
    .busy_o       (busy_o)
  );

  always @(negedge clk) begin
    if (snoop_port_o.ac_valid) ac_cnt++;
    if (snoop_port_o.cd_ready) cd_rdy_cnt++;
  end

  task automatic send_req(input logic [63:0] a, input logic [3:0] s);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_snoop_i = s;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_ac(input int delay, output bit ok, output logic [63:0] a,
                         output logic [3:0] s, output bit stable);
    ok = 1'b0; stable = 1'b1; a = '0; s = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (snoop_port_o.ac_valid) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      a = snoop_port_o.ac.addr;
      s = snoop_port_o.ac.snoop;
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        if (!snoop_port_o.ac_valid || snoop_port_o.ac.addr != a || snoop_port_o.ac.snoop != s)
          stable = 1'b0;
      end
      snoop_port_i.ac_ready = 1'b1;
      @(negedge clk);
      snoop_port_i.ac_ready = 1'b0;
    end
  endtask

  task automatic drive_cr(input crresp_t cr);
    snoop_port_i.cr_valid = 1'b1;
    snoop_port_i.cr_resp  = cr;
    @(negedge clk);
    snoop_port_i.cr_valid = 1'b0;
    snoop_port_i.cr_resp  = '0;
  endtask

  task automatic drive_cd(input int gap, input logic [63:0] d, input logic last);
    repeat (gap) @(negedge clk);
    snoop_port_i.cd_valid = 1'b1;
    snoop_port_i.cd.data  = d;
    snoop_port_i.cd.last  = last;
    @(negedge clk);
    snoop_port_i.cd_valid = 1'b0;
    snoop_port_i.cd       = '0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (resp_valid_o) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic take_resp();
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b rv=%b required 1 0 0", req_ready_o, busy_o, resp_valid_o);
    end
    checks++;
    if (snoop_port_o.ac_valid !== 1'b0 || snoop_port_o.cr_ready !== 1'b0 || snoop_port_o.cd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_snoop: got ac_valid=%b cr_ready=%b cd_ready=%b required 0 0 0",
               snoop_port_o.ac_valid, snoop_port_o.cr_ready, snoop_port_o.cd_ready);
    end
    checks++;
    if (resp_o !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %h required 0", resp_o);
    end
  endtask

  task automatic test_miss();
    bit ok, st;
    logic [63:0] a;
    logic [3:0] s;
    int cd0;
    send_req(64'h0000_0000_8000_0048, READ_ONCE);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL miss_busy: got %b required 1", busy_o); end
    wait_ac(0, ok, a, s, st);
    checks++;
    if (!ok || a !== 64'h0000_0000_8000_0040 || s !== 4'h0) begin
      errors++;
      $display("FAIL miss_ac: got ok=%b addr=%h snoop=%h required 1 0000000080000040 0", ok, a, s);
    end
    cd0 = cd_rdy_cnt;
    drive_cr(4'b0000);
    wait_resp(ok);
    checks++;
    if (!ok || resp_o !== '0) begin
      errors++;
      $display("FAIL miss_resp: got ok=%b resp=%h required 1 0", ok, resp_o);
    end
    checks++;
    if (cd_rdy_cnt != cd0) begin
      errors++;
      $display("FAIL miss_no_cd_ready: got %0d cd_ready cycles required 0", cd_rdy_cnt - cd0);
    end
    take_resp();
  endtask

  task automatic test_hit();
    bit ok, st;
    logic [63:0] a;
    logic [3:0] s;
    crresp_t cr;
    snoop_init_resp_t exp;
    send_req(64'h0000_0000_1000_0010, READ_SHARED);
    wait_ac(0, ok, a, s, st);
    checks++;
    if (!ok || a !== 64'h0000_0000_1000_0010 || s !== 4'h1) begin
      errors++;
      $display("FAIL hit_ac: got ok=%b addr=%h snoop=%h required 1 0000000010000010 1", ok, a, s);
    end
    cr = '0; cr.dataTransfer = 1'b1; cr.isShared = 1'b1;
    drive_cr(cr);
    drive_cd(0, 64'h1111_1111_1111_1111, 1'b0);
    drive_cd(0, 64'h2222_2222_2222_2222, 1'b1);
    exp = '0; exp.dataTransfer = 1'b1; exp.isShared = 1'b1;
    exp.line = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wait_resp(ok);
    checks++;
    if (!ok || resp_o !== exp) begin
      errors++;
      $display("FAIL hit_resp: got ok=%b resp=%h required %h", ok, resp_o, exp);
    end
    take_resp();
  endtask

  task automatic test_dirty();
    bit ok, st;
    logic [63:0] a;
    logic [3:0] s;
    crresp_t cr;
    snoop_init_resp_t exp;
    send_req(64'h0000_00AB_CDEF_003F, CLEAN_INVALID);
    wait_ac(5, ok, a, s, st);
    checks++;
    if (!ok || !st || a !== 64'h0000_00AB_CDEF_0030 || s !== 4'h9) begin
      errors++;
      $display("FAIL dirty_ac: got ok=%b stable=%b addr=%h snoop=%h required 1 1 000000abcdef0030 9", ok, st, a, s);
    end
    cr = '0; cr.dataTransfer = 1'b1; cr.passDirty = 1'b1;
    drive_cr(cr);
    drive_cd(3, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    drive_cd(3, 64'h5555_6666_7777_8888, 1'b1);
    exp = '0; exp.dataTransfer = 1'b1; exp.passDirty = 1'b1;
    exp.line = {64'h5555_6666_7777_8888, 64'hAAAA_BBBB_CCCC_DDDD};
    wait_resp(ok);
    checks++;
    if (!ok || resp_o !== exp) begin
      errors++;
      $display("FAIL dirty_resp: got ok=%b resp=%h required %h", ok, resp_o, exp);
    end
    take_resp();
  endtask

  task automatic test_illegal();
    int ac0, n;
    snoop_init_resp_t exp;
    ac0 = ac_cnt;
    send_req(64'h0000_0000_4000_0000, 4'hF);
    n = 1;
    while (!resp_valid_o && n < 2) begin @(negedge clk); n++; end
    exp = '0; exp.error = 1'b1;
    checks++;
    if (resp_valid_o !== 1'b1 || resp_o !== exp) begin
      errors++;
      $display("FAIL illegal_resp: got rv=%b resp=%h required 1 %h", resp_valid_o, resp_o, exp);
    end
    take_resp();
    checks++;
    if (ac_cnt != ac0) begin
      errors++;
      $display("FAIL illegal_no_ac: got %0d ac_valid cycles required 0", ac_cnt - ac0);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_idle: got req_ready=%b required 1", req_ready_o);
    end
  endtask

  task automatic test_bad_last();
    bit ok, st;
    logic [63:0] a;
    logic [3:0] s;
    crresp_t cr;
    snoop_init_resp_t exp;
    send_req(64'h0000_0000_2000_0000, READ_UNIQUE);
    wait_ac(0, ok, a, s, st);
    cr = '0; cr.dataTransfer = 1'b1;
    drive_cr(cr);
    drive_cd(0, 64'h0123_4567_89AB_CDEF, 1'b1);
    drive_cd(1, 64'hFEDC_BA98_7654_3210, 1'b0);
    exp = '0; exp.dataTransfer = 1'b1; exp.error = 1'b1;
    exp.line = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    wait_resp(ok);
    checks++;
    if (!ok || resp_o !== exp) begin
      errors++;
      $display("FAIL bad_last_resp: got ok=%b resp=%h required %h", ok, resp_o, exp);
    end
    take_resp();
  endtask

  task automatic test_backpressure_reset();
    bit ok, st, steady;
    logic [63:0] a;
    logic [3:0] s;
    crresp_t cr;
    snoop_init_resp_t exp, r0;
    send_req(64'h0000_0000_3000_0008, READ_SHARED);
    wait_ac(0, ok, a, s, st);
    cr = '0; cr.dataTransfer = 1'b1;
    drive_cr(cr);
    drive_cd(0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    drive_cd(0, 64'hCAFE_F00D_0000_0002, 1'b1);
    wait_resp(ok);
    exp = '0; exp.dataTransfer = 1'b1;
    exp.line = {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001};
    r0 = resp_o;
    steady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_o !== r0 || resp_valid_o !== 1'b1) steady = 1'b0;
    end
    checks++;
    if (!ok || !steady || r0 !== exp) begin
      errors++;
      $display("FAIL backpressure: got ok=%b steady=%b resp=%h required 1 1 %h", ok, steady, r0, exp);
    end
    take_resp();

    send_req(64'h0000_0000_5000_0000, READ_UNIQUE);
    wait_ac(0, ok, a, s, st);
    drive_cr(cr);
    drive_cd(0, 64'h9999_9999_9999_9999, 1'b0);
    checks++;
    if (snoop_port_o.cd_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_wait_cd: got cd_ready=%b required 1", snoop_port_o.cd_ready);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || resp_valid_o !== 1'b0 ||
        snoop_port_o.ac_valid !== 1'b0 || snoop_port_o.cr_ready !== 1'b0 ||
        snoop_port_o.cd_ready !== 1'b0 || resp_o !== '0) begin
      errors++;
      $display("FAIL midop_reset: got ready=%b busy=%b rv=%b ac=%b cr=%b cd=%b resp=%h required 1 0 0 0 0 0 0",
               req_ready_o, busy_o, resp_valid_o, snoop_port_o.ac_valid, snoop_port_o.cr_ready,
               snoop_port_o.cd_ready, resp_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    send_req(64'h1234_5678_9ABC_DEF7, READ_UNIQUE);
    wait_ac(2, ok, a, s, st);
    checks++;
    if (!ok || !st || a !== 64'h1234_5678_9ABC_DEF0 || s !== 4'h7) begin
      errors++;
      $display("FAIL post_reset_ac: got ok=%b stable=%b addr=%h snoop=%h required 1 1 123456789abcdef0 7", ok, st, a, s);
    end
    cr = '0; cr.isShared = 1'b1;
    drive_cr(cr);
    exp = '0; exp.isShared = 1'b1;
    wait_resp(ok);
    checks++;
    if (!ok || resp_o !== exp) begin
      errors++;
      $display("FAIL post_reset_resp: got ok=%b resp=%h required %h", ok, resp_o, exp);
    end
    take_resp();
  endtask

  initial begin
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_snoop_i  = '0;
    resp_ready_i = 1'b0;
    snoop_port_i = '0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    test_reset();
    test_miss();
    test_hit();
    test_dirty();
    test_illegal();
    test_bad_last();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
